// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss block-fill sequencer; optional saturating miss counter under CACHE_FILL_MISS_CNT_EN
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [6:0]        set_index,
  output logic [2:0]        word_index,
`ifdef CACHE_FILL_MISS_CNT_EN
  output logic [15:0]       miss_count,
`endif
  output logic [DATA_W-1:0] fill_data
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [ADDR_W-5:0] base;
  logic [3:0] req_cnt;
  logic [3:0] rcv_cnt;
  logic fill;
  logic rcv;
  logic last;
  logic unused_offset;
  assign unused_offset = ^miss_address[3:0];
  // decode of the fill state: request window, received word, final word
  always_comb begin
    fill = state == FILL;
    rcv = fill & memory_data_valid;
    last = rcv & (rcv_cnt == 4'd7);
    fsm_busy = fill | miss_detected;
    memory_read = fill & ~req_cnt[3];
    memory_address = memory_read ? {base, req_cnt[2:0], 1'b0} : '0;
    write_data_array = rcv;
    write_tag_array = last;
    word_index = rcv ? rcv_cnt[2:0] : 3'd0;
    set_index = fill ? base[6:0] : miss_address[10:4];
    fill_data = memory_data;
  end
  // state, block base and request/receive counters; misses are ignored mid-fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else if (!fill) begin
      req_cnt <= '0;
      rcv_cnt <= '0;
      if (miss_detected) begin
        state <= FILL;
        base <= miss_address[ADDR_W-1:4];
      end
    end else begin
      req_cnt <= req_cnt[3] ? req_cnt : req_cnt + 4'd1;
      if (rcv) rcv_cnt <= rcv_cnt + 4'd1;
      if (last) state <= IDLE;
    end
  end
`ifdef CACHE_FILL_MISS_CNT_EN
  // saturating count of accepted misses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) miss_count <= '0;
    else if (!fill && miss_detected && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench with a cycle-level fill model and a 4-cycle pipelined memory
module tb_cache_fill_fsm;
  logic clk = 0;
  logic rst = 1;
  logic miss_detected = 0;
  logic [15:0] miss_address = 16'h0;
  logic [15:0] memory_data;
  logic memory_data_valid;
  logic fsm_busy, memory_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_data;
  logic [6:0] set_index;
  logic [2:0] word_index;
`ifdef CACHE_FILL_MISS_CNT_EN
  logic [15:0] miss_count;
`endif
  int total = 0;
  int passed = 0;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .memory_read(memory_read), .memory_address(memory_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .set_index(set_index), .word_index(word_index),
`ifdef CACHE_FILL_MISS_CNT_EN
    .miss_count(miss_count),
`endif
    .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask

  // memory: a read issued in cycle k returns data in cycle k+4
  logic [3:0] pv = '0;
  logic [15:0] pa [4];
  logic force_v = 0;
  logic [15:0] force_d = 16'h0;
  assign memory_data_valid = pv[3] | force_v;
  assign memory_data = pv[3] ? (pa[3] ^ 16'h5A5A) : force_d;
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else begin
      pv <= {pv[2:0], memory_read};
      pa[0] <= memory_address;
      for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
    end
  end

  // model: a fill is a window of cycles after the accepting edge; requests in cycles 1..8, ends on the 8th word
  logic in_fill = 0;
  int cyc = 0;
  int s = 0;
  logic [11:0] mbase = '0;
  logic [2:0] nv = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) in_fill <= 0;
    else begin
      cyc <= cyc + 1;
      if (in_fill) begin
        if (memory_data_valid) begin
          nv <= nv + 3'd1;
          if (nv == 3'd7) in_fill <= 0;
        end
      end else if (miss_detected) begin
        in_fill <= 1;
        s <= cyc;
        mbase <= miss_address[15:4];
        nv <= '0;
      end
    end
  end

  always @(negedge clk) begin
    automatic int k = cyc - s;
    automatic logic er = in_fill && k >= 1 && k <= 8;
    automatic logic [15:0] ea = er ? ({mbase, 4'h0} + 16'(2 * (k - 1))) : 16'h0;
    automatic logic ew = in_fill && memory_data_valid;
    chk("busy", 32'(fsm_busy), 32'(in_fill | miss_detected));
    chk("read", 32'(memory_read), 32'(er));
    chk("addr", 32'(memory_address), 32'(ea));
    chk("wda", 32'(write_data_array), 32'(ew));
    chk("wta", 32'(write_tag_array), 32'(ew && nv == 3'd7));
    chk("wi", 32'(word_index), ew ? 32'(nv) : 32'h0);
    chk("set", 32'(set_index), in_fill ? 32'(mbase[6:0]) : 32'(miss_address[10:4]));
    chk("fdata", 32'(fill_data), 32'(memory_data));
  end

  // monitor of issued addresses, written word indices, busy cycles and tag writes
  logic [15:0] qa[$];
  logic [2:0] qw[$];
  int nbusy = 0;
  int ntag = 0;
  always @(negedge clk) begin
    if (memory_read) qa.push_back(memory_address);
    if (write_data_array) qw.push_back(word_index);
    if (fsm_busy) nbusy++;
    if (write_tag_array) ntag++;
  end

  task automatic clr();
    qa.delete();
    qw.delete();
    nbusy = 0;
    ntag = 0;
  endtask

  task automatic start_miss(input logic [15:0] a);
    @(posedge clk); #2;
    miss_detected = 1;
    miss_address = a;
    @(posedge clk); #2;
    miss_detected = 0;
  endtask

  task automatic wait_idle();
    automatic bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!fsm_busy) done = 1;
    end
    if (!done) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_tag();
    automatic bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (write_tag_array) done = 1;
    end
    if (!done) chk("tag_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(fsm_busy), 32'h0);
    chk("rst_read", 32'(memory_read), 32'h0);
    chk("rst_addr", 32'(memory_address), 32'h0);
    chk("rst_wda", 32'(write_data_array), 32'h0);
    chk("rst_wta", 32'(write_tag_array), 32'h0);
    chk("rst_wi", 32'(word_index), 32'h0);
    @(posedge clk); #2;
    rst = 0;

    clr();
    start_miss(16'h1234);
    @(negedge clk);
    chk("t1_set", 32'(set_index), 32'h23);
    wait_idle();
    chk("t1_nreq", 32'(qa.size()), 32'd8);
    for (int i = 0; i < 8 && i < qa.size(); i++) chk("t1_addr", 32'(qa[i]), 32'h1230 + 32'(2 * i));
    chk("t1_nwr", 32'(qw.size()), 32'd8);
    for (int i = 0; i < 8 && i < qw.size(); i++) chk("t1_wi", 32'(qw[i]), 32'(i));
    chk("t1_ntag", 32'(ntag), 32'd1);
    chk("t1_busy_cycles", 32'(nbusy), 32'd13);

    clr();
    @(posedge clk); #2;
    miss_detected = 1;
    miss_address = 16'h5670;
    @(posedge clk); #2;
    miss_address = 16'hFFF0;
    wait_tag();
    miss_detected = 0;
    wait_idle();
    chk("t2_nreq", 32'(qa.size()), 32'd8);
    if (qa.size() == 8) begin
      chk("t2_addr0", 32'(qa[0]), 32'h5670);
      chk("t2_addr7", 32'(qa[7]), 32'h567E);
    end
    chk("t2_ntag", 32'(ntag), 32'd1);

    @(posedge clk); #2;
    force_v = 1;
    force_d = 16'hBEEF;
    @(negedge clk);
    chk("t3_wda", 32'(write_data_array), 32'h0);
    chk("t3_wta", 32'(write_tag_array), 32'h0);
    chk("t3_fdata", 32'(fill_data), 32'hBEEF);
    @(posedge clk); #2;
    force_v = 0;

    clr();
    start_miss(16'h0800);
    for (int i = 0; i < 40 && qw.size() < 3; i++) @(negedge clk);
    chk("t4_three", 32'(qw.size()), 32'd3);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("t4_busy", 32'(fsm_busy), 32'h0);
    chk("t4_read", 32'(memory_read), 32'h0);
    chk("t4_addr", 32'(memory_address), 32'h0);
    chk("t4_wda", 32'(write_data_array), 32'h0);
    chk("t4_wi", 32'(word_index), 32'h0);
    chk("t4_ntag", 32'(ntag), 32'd0);
    @(posedge clk); #2;
    rst = 0;
    clr();
    start_miss(16'h0040);
    wait_idle();
    if (qa.size() > 0) chk("t4_restart_addr", 32'(qa[0]), 32'h0040);
    else chk("t4_restart_nreq", 32'h0, 32'h1);
    if (qw.size() > 0) chk("t4_restart_wi", 32'(qw[0]), 32'h0);
    else chk("t4_restart_nwr", 32'h0, 32'h1);
    chk("t4_restart_ntag", 32'(ntag), 32'd1);

    clr();
    start_miss(16'h0010);
    wait_tag();
    chk("t5_set_a", 32'(set_index), 32'h01);
    @(posedge clk); #2;
    miss_detected = 1;
    miss_address = 16'h0FF0;
    @(negedge clk);
    chk("t5_gap_busy", 32'(fsm_busy), 32'h1);
    chk("t5_set_b", 32'(set_index), 32'h7F);
    @(posedge clk); #2;
    miss_detected = 0;
    wait_idle();
    chk("t5_nreq", 32'(qa.size()), 32'd16);
    if (qa.size() == 16) chk("t5_addr8", 32'(qa[8]), 32'h0FF0);
    chk("t5_busy_cycles", 32'(nbusy), 32'd26);
    chk("t5_ntag", 32'(ntag), 32'd2);

`ifdef CACHE_FILL_MISS_CNT_EN
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("cnt_rst", 32'(miss_count), 32'h0);
    @(posedge clk); #2;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      start_miss(16'h2000 + 16'(i * 16));
      wait_idle();
    end
    chk("cnt_three", 32'(miss_count), 32'd3);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("cnt_clear", 32'(miss_count), 32'h0);
    @(posedge clk); #2;
    rst = 0;
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
